csi2_line_monitor: RTL and testbench
====================================

# csi2_line_monitor

Byte-clock stage between the CSI-2 receiver IP and the byte-to-pixel IP. It carries the fixed alignment delays the byte-to-pixel converter needs: 1 cycle on `sp_en`/`lp_av_en`, 3 cycles on the payload. It also tracks frame and line structure from short and long packets, checks every long packet's received byte count against its header word count, and reports lines per frame, frame count and sticky error flags for camera bring-up and debug.

## Interface
- `REF_DT`, 6'h2B: long-packet data type that is counted as an image line (RAW10).
- `byte_clk_hs`  in  1  byte clock from the D-PHY receiver.
- `reset_n_clock_96MHz`  in  1  reset, asynchronous, active-low.
- `sp_en_i`  in  1  short-packet strobe from the receiver.
- `lp_av_en_i`  in  1  long-packet header strobe for `REF_DT`.
- `datatype_i`  in  6  packet data type, valid with `sp_en_i`/`lp_av_en_i`.
- `word_count_i`  in  16  long-packet word count; the frame number for short packets.
- `payload_en_i`  in  1  payload byte valid.
- `payload_i`  in  8  payload byte.
- `clear_i`  in  1  single-cycle pulse that clears the sticky errors and the error counter.
- `sp_en_o`, `lp_av_en_o`  out  1  inputs delayed by 1 cycle.
- `payload_en_o`  out  1  input delayed by 3 cycles.
- `payload_o`  out  8  input delayed by 3 cycles.
- `frame_active_o`  out  1  high between Frame Start and Frame End.
- `line_count_o`  out  12  lines in the current frame, saturating at 4095.
- `last_frame_lines_o`  out  12  `line_count` latched at Frame End.
- `frame_count_o`  out  8  completed frames, wraps.
- `wc_error_o`  out  1  sticky: byte count did not match the word count.
- `sync_error_o`  out  1  sticky: a packet arrived out of sequence.
- `error_count_o`  out  8  total error events, saturating at 255.

## Operation
- Delay lines are plain registers and run regardless of state or errors. The data path is never gated.
- FSM states:
  - IDLE: no frame is open.
  - FRAME: inside a frame, between lines.
  - LINE: receiving a counted long packet.
- Frame Start is `sp_en_i` && `datatype_i`==6'h00.
  - IDLE → FRAME; `line_count` is set to 0.
  - In FRAME: raise `sync_error`, restart the frame (`line_count` set to 0).
  - In LINE: raise `sync_error` (truncated line, no `wc_error`), go to FRAME with `line_count` set to 0.
- Frame End is `sp_en_i` && `datatype_i`==6'h01.
  - FRAME → IDLE: latch `last_frame_lines`, increment `frame_count`.
  - In IDLE: raise `sync_error`, no count change.
  - In LINE: raise `sync_error`, then close the frame exactly as from FRAME.
- Line start is `lp_av_en_i` && `datatype_i`==`REF_DT`.
  - FRAME → LINE: `expected` is set to `word_count_i`, `bytes` is set to 0.
  - In IDLE: raise `sync_error`; the packet is not counted.
- In LINE, each `payload_en_i` cycle increments `bytes` (16 bit, saturating). Line end is the first cycle with `payload_en_i`=0 after at least one byte:
  - compare `bytes` with `expected`; on mismatch raise `wc_error`;
  - increment `line_count` either way;
  - go to FRAME.
- A word count of 0 ends the line on the header cycle + 1 with no bytes. The line counts; there is no error.
- Other short packet types (line start/end, generic) are ignored.
- Each error event increments `error_count` once. Two sticky errors in the same cycle add 2.
- `clear_i` zeroes the flags and `error_count`. If an error occurs in the same cycle, the error wins (flag set, count = 1 or 2).
- Reset: all outputs 0, FSM in IDLE, delay lines zeroed.

## Timing
- `sp_en_o`/`lp_av_en_o` lag their inputs by exactly 1 cycle. `payload_*_o` lag by exactly 3 cycles.
- Status outputs are registered and update the cycle after the triggering input cycle.
  - `frame_active_o` rises 1 cycle after Frame Start and falls 1 cycle after Frame End.
  - `line_count_o` increments 1 cycle after the line-end cycle.
- Back-to-back events are handled without loss:
  - a line header on the cycle right after line end;
  - Frame End on the cycle right after line end.
- Reset assertion mid-line clears everything asynchronously. After release the FSM waits in IDLE for the next Frame Start; partial lines are not counted.

## Structure
- The shared camera package holds:
  - the FSM enum (IDLE, FRAME, LINE);
  - data-type constants DT_FRAME_START=6'h00, DT_FRAME_END=6'h01, DT_RAW10=6'h2B.
- One natural sub-module is `csi2_delay_line` (parameters WIDTH and DEPTH), instantiated for the 1-cycle strobes and the 3-cycle payload.
- The checker FSM and its counters stay in this module.

## Test plan
- Frame Start, 4 lines of `word_count` 1600 with 1600 bytes each, then Frame End:
  - `line_count_o`=4, `last_frame_lines_o`=4, `frame_count_o`=1;
  - no errors;
  - `payload_o` equals the input delayed by 3 cycles.
- One line with `word_count` 1600 but 1599 bytes: `wc_error_o`=1, `error_count_o`=1, `line_count_o` still increments.
- Long packet before any Frame Start: `sync_error_o`=1, `line_count_o`=0, `frame_active_o`=0.
- Frame End arriving mid-line: `sync_error_o`=1, frame closes, `frame_count_o`+1, FSM returns to IDLE.
- Reset pulse mid-line, then a clean 2-line frame: all status is 0 after reset; afterwards `last_frame_lines_o`=2, `frame_count_o`=1.
- `clear_i` in the same cycle as a `wc_error` event: `wc_error_o`=1, `error_count_o`=1.

Source files
------------

// File: rtl/csi2_line_monitor_pkg.sv
// Shared camera package: checker FSM states, CSI-2 data types, saturating helpers.
package csi2_line_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FRAME,
      LINE
   } mon_state_t;

   localparam logic [5:0] DT_FRAME_START = 6'h00;
   localparam logic [5:0] DT_FRAME_END   = 6'h01;
   localparam logic [5:0] DT_RAW10       = 6'h2B;

   // Adds up to two error events to an 8-bit counter, holding at 255.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {7'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/csi2_line_monitor_if.sv
// Packet bus from the CSI-2 receiver IP into the line monitor.
interface csi2_line_monitor_if;
   logic        sp_en;
   logic        lp_av_en;
   logic [5:0]  datatype;
   logic [15:0] word_count;
   logic        payload_en;
   logic [7:0]  payload;

   modport master (
      output sp_en, lp_av_en, datatype, word_count, payload_en, payload
   );

   modport slave (
      input sp_en, lp_av_en, datatype, word_count, payload_en, payload
   );
endinterface

// File: rtl/csi2_delay_line.sv
// Fixed-length register delay line, cleared by the asynchronous reset.
module csi2_delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             byte_clk_hs,
   input  logic             reset_n_clock_96MHz,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift the input through DEPTH register stages every cycle.
   always_ff @(posedge byte_clk_hs or negedge reset_n_clock_96MHz) begin
      if (!reset_n_clock_96MHz) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/csi2_line_monitor.sv
// Byte-clock alignment stage plus frame/line structure and word-count checker.
module csi2_line_monitor
   import csi2_line_monitor_pkg::*;
#(
   parameter logic [5:0] REF_DT = DT_RAW10
) (
   input  logic                       byte_clk_hs,
   input  logic                       reset_n_clock_96MHz,
   csi2_line_monitor_if.slave         rx,
   input  logic                       clear_i,
   output logic                       sp_en_o,
   output logic                       lp_av_en_o,
   output logic                       payload_en_o,
   output logic [7:0]                 payload_o,
   output logic                       frame_active_o,
   output logic [11:0]                line_count_o,
   output logic [11:0]                last_frame_lines_o,
   output logic [7:0]                 frame_count_o,
   output logic                       wc_error_o,
   output logic                       sync_error_o,
   output logic [7:0]                 error_count_o
);

   csi2_delay_line #(.WIDTH(2), .DEPTH(1)) u_strobe_dly (
      .byte_clk_hs         (byte_clk_hs),
      .reset_n_clock_96MHz (reset_n_clock_96MHz),
      .din                 ({rx.sp_en, rx.lp_av_en}),
      .dout                ({sp_en_o, lp_av_en_o})
   );

   csi2_delay_line #(.WIDTH(9), .DEPTH(3)) u_payload_dly (
      .byte_clk_hs         (byte_clk_hs),
      .reset_n_clock_96MHz (reset_n_clock_96MHz),
      .din                 ({rx.payload_en, rx.payload}),
      .dout                ({payload_en_o, payload_o})
   );

   mon_state_t  state_q, state_d;
   logic [11:0] line_q, line_d;
   logic [11:0] last_q, last_d;
   logic [7:0]  frame_q, frame_d;
   logic [15:0] expected_q, expected_d;
   logic [15:0] bytes_q, bytes_d;
   logic        wc_err_q, sync_err_q;
   logic [7:0]  err_cnt_q;
   logic        frame_act_q;
   logic        sync_ev, wc_ev;
   logic        is_fs, is_fe, is_ls;

   assign is_fs = rx.sp_en    && (rx.datatype == DT_FRAME_START);
   assign is_fe = rx.sp_en    && (rx.datatype == DT_FRAME_END);
   assign is_ls = rx.lp_av_en && (rx.datatype == REF_DT);

   // Register FSM state, counters and sticky error status.
   always_ff @(posedge byte_clk_hs or negedge reset_n_clock_96MHz) begin
      if (!reset_n_clock_96MHz) begin
         state_q     <= IDLE;
         line_q      <= '0;
         last_q      <= '0;
         frame_q     <= '0;
         expected_q  <= '0;
         bytes_q     <= '0;
         wc_err_q    <= 1'b0;
         sync_err_q  <= 1'b0;
         err_cnt_q   <= '0;
         frame_act_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         last_q      <= last_d;
         frame_q     <= frame_d;
         expected_q  <= expected_d;
         bytes_q     <= bytes_d;
         frame_act_q <= (state_d != IDLE);
         // A new error event outranks a simultaneous clear.
         if (clear_i) begin
            wc_err_q   <= wc_ev;
            sync_err_q <= sync_ev;
            err_cnt_q  <= sat_add8('0, {1'b0, wc_ev} + {1'b0, sync_ev});
         end else begin
            wc_err_q   <= wc_err_q | wc_ev;
            sync_err_q <= sync_err_q | sync_ev;
            err_cnt_q  <= sat_add8(err_cnt_q, {1'b0, wc_ev} + {1'b0, sync_ev});
         end
      end
   end

   // Next-state, counter updates and error events; frame markers outrank payload.
   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      last_d     = last_q;
      frame_d    = frame_q;
      expected_d = expected_q;
      bytes_d    = bytes_q;
      sync_ev    = 1'b0;
      wc_ev      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (is_fs) begin
               state_d = FRAME;
               line_d  = '0;
            end else if (is_fe || is_ls) begin
               sync_ev = 1'b1;
            end
         end
         FRAME: begin
            if (is_fs) begin
               sync_ev = 1'b1;
               line_d  = '0;
            end else if (is_fe) begin
               state_d = IDLE;
               last_d  = line_q;
               frame_d = frame_q + 8'd1;
            end else if (is_ls) begin
               state_d    = LINE;
               expected_d = rx.word_count;
               bytes_d    = '0;
            end
         end
         LINE: begin
            if (is_fs) begin
               sync_ev = 1'b1;
               state_d = FRAME;
               line_d  = '0;
            end else if (is_fe) begin
               sync_ev = 1'b1;
               state_d = IDLE;
               last_d  = line_q;
               frame_d = frame_q + 8'd1;
            end else if (rx.payload_en) begin
               bytes_d = (bytes_q == '1) ? bytes_q : bytes_q + 16'd1;
            end else if ((bytes_q != '0) || (expected_q == '0)) begin
               wc_ev   = (bytes_q != expected_q);
               line_d  = (line_q == '1) ? line_q : line_q + 12'd1;
               state_d = FRAME;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign frame_active_o     = frame_act_q;
   assign line_count_o       = line_q;
   assign last_frame_lines_o = last_q;
   assign frame_count_o      = frame_q;
   assign wc_error_o         = wc_err_q;
   assign sync_error_o       = sync_err_q;
   assign error_count_o      = err_cnt_q;

endmodule

// File: tb/tb_csi2_line_monitor.sv
// Directed bench for csi2_line_monitor with hand-computed expectations.
module tb_csi2_line_monitor;

   logic        byte_clk_hs = 1'b0;
   logic        reset_n_clock_96MHz = 1'b0;
   logic        clear_i = 1'b0;
   logic        sp_en_o, lp_av_en_o, payload_en_o;
   logic [7:0]  payload_o;
   logic        frame_active_o;
   logic [11:0] line_count_o, last_frame_lines_o;
   logic [7:0]  frame_count_o, error_count_o;
   logic        wc_error_o, sync_error_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned dly_bad = 0;
   logic [8:0]  h0 = '0, h1 = '0, h2 = '0;

   csi2_line_monitor_if bus ();

   csi2_line_monitor #(.REF_DT(6'h2B)) dut (
      .byte_clk_hs         (byte_clk_hs),
      .reset_n_clock_96MHz (reset_n_clock_96MHz),
      .rx                  (bus),
      .clear_i             (clear_i),
      .sp_en_o             (sp_en_o),
      .lp_av_en_o          (lp_av_en_o),
      .payload_en_o        (payload_en_o),
      .payload_o           (payload_o),
      .frame_active_o      (frame_active_o),
      .line_count_o        (line_count_o),
      .last_frame_lines_o  (last_frame_lines_o),
      .frame_count_o       (frame_count_o),
      .wc_error_o          (wc_error_o),
      .sync_error_o        (sync_error_o),
      .error_count_o       (error_count_o)
   );

   always #5 byte_clk_hs = ~byte_clk_hs;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: record the presented payload, then sample #1 after the edge.
   task automatic tick();
      h2 = h1; h1 = h0; h0 = {bus.payload_en, bus.payload};
      @(posedge byte_clk_hs);
      #1;
      if (!reset_n_clock_96MHz) begin h0 = '0; h1 = '0; h2 = '0; end
      if ({payload_en_o, payload_o} !== h2) dly_bad++;
   endtask

   task automatic quiet();
      bus.sp_en = 1'b0; bus.lp_av_en = 1'b0; bus.datatype = '0;
      bus.word_count = '0; bus.payload_en = 1'b0; bus.payload = '0;
      clear_i = 1'b0;
   endtask

   task automatic send_sp(input logic [5:0] dt);
      quiet();
      bus.sp_en = 1'b1; bus.datatype = dt;
      tick();
      quiet();
   endtask

   task automatic send_hdr(input logic [15:0] wc);
      quiet();
      bus.lp_av_en = 1'b1; bus.datatype = 6'h2B; bus.word_count = wc;
      tick();
      quiet();
   endtask

   task automatic send_bytes(input int unsigned n, input logic [7:0] seed);
      for (int unsigned i = 0; i < n; i++) begin
         bus.payload_en = 1'b1;
         bus.payload    = 8'(i) ^ seed;
         tick();
      end
      quiet();
   endtask

   // Header, n bytes, then the line-end cycle (payload_en low), optional clear on it.
   task automatic send_line(input logic [15:0] wc, input int unsigned n, input logic clr);
      send_hdr(wc);
      send_bytes(n, wc[7:0]);
      clear_i = clr;
      tick();
      quiet();
   endtask

   initial begin
      quiet();
      // Reset state
      repeat (3) tick();
      check_val("rst_line_count", line_count_o, 0);
      check_val("rst_frame_active", frame_active_o, 0);
      check_val("rst_frame_count", frame_count_o, 0);
      check_val("rst_err_count", error_count_o, 0);
      check_val("rst_payload", {payload_en_o, payload_o}, 0);
      reset_n_clock_96MHz = 1'b1;
      tick();

      // Long packet before any Frame Start
      send_hdr(16'd4);
      send_bytes(4, 8'h11);
      tick();
      check_val("idle_lp_sync", sync_error_o, 1);
      check_val("idle_lp_errcnt", error_count_o, 1);
      check_val("idle_lp_lines", line_count_o, 0);
      check_val("idle_lp_active", frame_active_o, 0);
      clear_i = 1'b1; tick(); quiet();
      check_val("clear_sync", sync_error_o, 0);
      check_val("clear_errcnt", error_count_o, 0);

      // Clean frame: 4 lines of 1600, back-to-back headers and Frame End
      send_sp(6'h00);
      check_val("fs_active", frame_active_o, 1);
      check_val("fs_sp_en_o", sp_en_o, 1);
      tick();
      check_val("sp_en_o_drop", sp_en_o, 0);
      send_hdr(16'd1600);
      check_val("hdr_lp_av_en_o", lp_av_en_o, 1);
      send_bytes(1600, 8'h5A);
      tick();
      check_val("line1_count", line_count_o, 1);
      for (int unsigned l = 0; l < 3; l++) send_line(16'd1600, 1600, 1'b0);
      check_val("line4_count", line_count_o, 4);
      send_sp(6'h01);
      check_val("f1_active", frame_active_o, 0);
      check_val("f1_line_count", line_count_o, 4);
      check_val("f1_last_lines", last_frame_lines_o, 4);
      check_val("f1_frame_count", frame_count_o, 1);
      check_val("f1_wc_err", wc_error_o, 0);
      check_val("f1_sync_err", sync_error_o, 0);
      check_val("f1_err_count", error_count_o, 0);
      check_val("f1_payload_dly", dly_bad, 0);

      // Short line, then a zero word-count line
      send_sp(6'h00);
      check_val("f2_lines_reset", line_count_o, 0);
      send_line(16'd1600, 1599, 1'b0);
      check_val("short_wc_err", wc_error_o, 1);
      check_val("short_err_count", error_count_o, 1);
      check_val("short_line_count", line_count_o, 1);
      send_line(16'd0, 0, 1'b0);
      check_val("wc0_line_count", line_count_o, 2);
      check_val("wc0_err_count", error_count_o, 1);
      send_sp(6'h01);
      check_val("f2_last_lines", last_frame_lines_o, 2);
      check_val("f2_frame_count", frame_count_o, 2);
      clear_i = 1'b1; tick(); quiet();
      check_val("clear_wc", wc_error_o, 0);

      // Frame End arriving mid-line
      send_sp(6'h00);
      send_hdr(16'd100);
      send_bytes(10, 8'h33);
      send_sp(6'h01);
      check_val("fe_mid_sync", sync_error_o, 1);
      check_val("fe_mid_errcnt", error_count_o, 1);
      check_val("fe_mid_active", frame_active_o, 0);
      check_val("fe_mid_frames", frame_count_o, 3);
      check_val("fe_mid_last", last_frame_lines_o, 0);
      check_val("fe_mid_wc", wc_error_o, 0);
      send_hdr(16'd4);
      check_val("fe_mid_idle_errcnt", error_count_o, 2);
      check_val("fe_mid_idle_lines", line_count_o, 0);

      // Clear coinciding with a word-count error
      send_sp(6'h00);
      send_line(16'd10, 9, 1'b1);
      check_val("clr_race_wc", wc_error_o, 1);
      check_val("clr_race_errcnt", error_count_o, 1);
      check_val("clr_race_sync", sync_error_o, 0);
      check_val("clr_race_lines", line_count_o, 1);
      send_sp(6'h01);
      check_val("f4_frame_count", frame_count_o, 4);

      // Asynchronous reset mid-line, then a clean 2-line frame
      send_sp(6'h00);
      send_hdr(16'd20);
      bus.payload_en = 1'b1; bus.payload = 8'hA5;
      repeat (5) tick();
      #2;
      reset_n_clock_96MHz = 1'b0;
      #1;
      h0 = '0; h1 = '0; h2 = '0;
      check_val("arst_frame_count", frame_count_o, 0);
      check_val("arst_line_count", line_count_o, 0);
      check_val("arst_wc", wc_error_o, 0);
      check_val("arst_active", frame_active_o, 0);
      check_val("arst_payload", {payload_en_o, payload_o}, 0);
      quiet();
      repeat (2) tick();
      reset_n_clock_96MHz = 1'b1;
      tick();
      send_sp(6'h00);
      send_line(16'd8, 8, 1'b0);
      send_line(16'd8, 8, 1'b0);
      send_sp(6'h01);
      check_val("post_rst_last", last_frame_lines_o, 2);
      check_val("post_rst_frames", frame_count_o, 1);
      check_val("post_rst_errcnt", error_count_o, 0);
      check_val("post_rst_sync", sync_error_o, 0);
      check_val("payload_dly_all", dly_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
